clken_dds: RTL and testbench
============================

CLKEN_DDS -- requirements
Module: clken_dds

Interface
REQ-001 Parameter NUM_CH, default 7, number of independent clock-enable channels (1..16).
REQ-002 Parameter ACC_W, default 24, phase-accumulator width in bits (8..32).
REQ-003 Parameter LOCK_CYCLES, default 1024, stable cycles required before locked asserts (>=1).
REQ-004 refclk  input  1  single master clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  one-cycle strobe that loads wr_inc into channel wr_ch.
REQ-007 wr_ch  input  4  target channel index for wr_en.
REQ-008 wr_inc  input  ACC_W  phase increment; output rate = f_refclk * wr_inc / 2^ACC_W.
REQ-009 sync  input  1  one-cycle strobe that phase-aligns all channels.
REQ-010 ce_en  input  NUM_CH  per-channel gate on ce output; accumulation continues when gated.
REQ-011 ce  output  NUM_CH  per-channel clock-enable pulses, one refclk cycle wide.
REQ-012 locked  output  1  high once configuration has been stable for LOCK_CYCLES cycles.

Function
REQ-013 Each refclk edge, per channel: {carry, acc_i} <= acc_i + inc_i (ACC_W+1-bit sum, modulo 2^ACC_W); ce[i] <= carry & ce_en[i].
REQ-014 ce and acc update on the same edge; ce is registered, with no combinational path from any input to ce.
REQ-015 inc_i = 0 never pulses; inc_i = 2^(ACC_W-1) pulses every 2nd cycle; inc_i = 2^ACC_W-1 pulses on all but one cycle per 2^ACC_W.
REQ-016 Accepted write (wr_en=1, wr_ch<NUM_CH) updates inc_i at that edge; the add on that same edge uses the old inc_i; acc_i is not cleared.
REQ-017 wr_en with wr_ch>=NUM_CH is ignored entirely: no increment change, no effect on lock.
REQ-018 sync=1: every acc_i <= 0 and every ce bit <= 0 at that edge, overriding any carry.
REQ-019 sync and wr_en in the same cycle: both apply; acc cleared, inc updated.
REQ-020 Lock counter: cleared to 0 and locked <= 0 on any accepted write or sync; otherwise increments, saturating at LOCK_CYCLES.
REQ-021 locked = 1 exactly when the counter equals LOCK_CYCLES: first high LOCK_CYCLES edges after the last clear.
REQ-022 ce_en change takes effect on the next ce update; it does not affect acc or lock.

Reset
REQ-023 rst=1 at an edge: all acc_i = 0, all inc_i = 0, ce = 0, lock counter = 0, locked = 0.
REQ-024 rst has priority over wr_en and sync in the same cycle.
REQ-025 Mid-operation reset discards all programmed increments; software reprograms after release.
REQ-026 With rst deasserted and no writes, all ce bits stay 0 indefinitely.

Structure
REQ-027 Shared package clken_dds_pkg holds ACC_W and LOCK_CYCLES defaults, plus a constant function inc_from_hz(f_out, f_ref, acc_w) returning round(f_out*2^acc_w/f_ref).
REQ-028 One sub-module, clken_dds_ch: one accumulator plus inc register and ce flop; the top instantiates it NUM_CH times with a generate loop and holds the write decode and lock counter.
REQ-029 The RTL SHALL contain no vendor primitives and no derived clocks; downstream logic runs on refclk qualified by ce.

Verification
REQ-030 ACC_W=24; write ch0 inc=0x400000 after reset, then idle -> ce[0] high once every 4 cycles, first pulse on the 4th edge after the write edge; locked rises exactly 1024 edges after the write.
REQ-031 refclk=96 MHz model, ch0..ch6 programmed for 16/24/32/40/48/96/80 MHz via inc_from_hz -> pulse counts over 96000 cycles equal 16000/24000/32000/40000/48000/95999..96000/80000 within +/-1.
REQ-032 ch2 inc=0x800000 running; sync asserted -> ce all 0 that cycle, acc cleared, ch2 pulses on the 2nd edge after sync; locked drops and takes 1024 edges to return.
REQ-033 Write with wr_ch=9 and NUM_CH=7 -> no ce change, locked remains high; ce_en[3]=0 -> ce[3] stays 0 while the internal acc keeps counting, and pulses resume in the same phase when ce_en[3] returns to 1.
REQ-034 rst asserted mid-run together with wr_en and sync -> all outputs 0 on the next cycle, inc unchanged at 0, no ce pulses until reprogrammed.
REQ-035 Boundary: inc=0xFFFFFF -> ce low exactly once per 2^24 cycles (checked with ACC_W=8, inc=0xFF -> one low per 256 cycles).

Source files
------------

// File: rtl/clken_dds_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : clken_dds_pkg
// Brief    : Shared defaults and increment helper for the clock-enable DDS.
// Revision : 1.0
// ============================================================================
package clken_dds_pkg;

    localparam int unsigned ACC_W_DEF       = 24;
    localparam int unsigned LOCK_CYCLES_DEF = 1024;

    // Rounded f_out*2^acc_w/f_ref, clamped so f_out == f_ref still fits acc_w bits.
    function automatic logic [63:0] inc_from_hz(
        input longint unsigned f_out,
        input longint unsigned f_ref,
        input int unsigned     acc_w
    );
        logic [63:0] num;
        logic [63:0] quo;
        logic [63:0] max_inc;
        num     = (64'(f_out) << acc_w) + 64'(f_ref / 2);
        quo     = num / 64'(f_ref);
        max_inc = (64'd1 << acc_w) - 64'd1;
        return (quo > max_inc) ? max_inc : quo;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clken_dds_ch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : clken_dds_ch
// Brief    : One DDS channel: increment register, phase accumulator, ce flop.
// Revision : 1.0
// ============================================================================
module clken_dds_ch
    import clken_dds_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] inc_in,
    input  logic             sync,
    input  logic             ce_en,
    output logic             ce
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic             r_ce;
    logic [ACC_W:0]   w_sum;

    // The add always uses the increment held before this edge's load.
    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_inc <= '0;
            r_ce  <= 1'b0;
        end else begin
            if (load) begin
                r_inc <= inc_in;
            end
            if (sync) begin
                r_acc <= '0;
                r_ce  <= 1'b0;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ce  <= w_sum[ACC_W] & ce_en;
            end
        end
    end

    assign ce = r_ce;

endmodule
`default_nettype wire

// File: rtl/clken_dds.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : clken_dds
// Brief    : Multi-channel DDS clock-enable generator with lock indication.
// Revision : 1.0
// ============================================================================
module clken_dds
    import clken_dds_pkg::*;
#(
    parameter int unsigned NUM_CH      = 7,
    parameter int unsigned ACC_W       = ACC_W_DEF,
    parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [3:0]        wr_ch,
    input  logic [ACC_W-1:0]  wr_inc,
    input  logic              sync,
    input  logic [NUM_CH-1:0] ce_en,
    output logic [NUM_CH-1:0] ce,
    output logic              locked
);

    localparam int unsigned          c_cnt_w    = $clog2(LOCK_CYCLES + 1);
    localparam logic [c_cnt_w-1:0]   c_lock_max = c_cnt_w'(LOCK_CYCLES);

    logic               w_wr_ok;
    logic [c_cnt_w-1:0] r_cnt;

    // Writes to channels that do not exist are dropped before they touch anything.
    assign w_wr_ok = wr_en && ({1'b0, wr_ch} < 5'(NUM_CH));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clken_dds_ch #(
            .ACC_W (ACC_W)
        ) u_ch (
            .clk    (refclk),
            .rst    (rst),
            .load   (w_wr_ok && (wr_ch == 4'(i))),
            .inc_in (wr_inc),
            .sync   (sync),
            .ce_en  (ce_en[i]),
            .ce     (ce[i])
        );
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_wr_ok || sync) begin
            r_cnt <= '0;
        end else if (r_cnt != c_lock_max) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign locked = (r_cnt == c_lock_max);

endmodule
`default_nettype wire

// File: tb/tb_clken_dds.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_clken_dds
// Brief    : Scoreboard bench for clken_dds (7-channel/24-bit and 1-channel/8-bit).
// Revision : 1.0
// ============================================================================
module tb_clken_dds;
    import clken_dds_pkg::*;

    logic        refclk;
    logic        rst, wr_en, sync;
    logic [3:0]  wr_ch;
    logic [23:0] wr_inc;
    logic [6:0]  ce_en, ce;
    logic        locked;

    logic        rst8, wr_en8, sync8, ce_en8, ce8, locked8;
    logic [3:0]  wr_ch8;
    logic [7:0]  wr_inc8;

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    int unsigned q_cyc[$];
    logic [6:0]  q_mask[$];
    logic [6:0]  q_ce[$];
    bit          q_cklk[$];
    bit          q_lk[$];
    string       q_name[$];

    clken_dds #(.NUM_CH(7), .ACC_W(24), .LOCK_CYCLES(1024)) dut (
        .refclk (refclk), .rst (rst), .wr_en (wr_en), .wr_ch (wr_ch),
        .wr_inc (wr_inc), .sync (sync), .ce_en (ce_en), .ce (ce), .locked (locked)
    );

    clken_dds #(.NUM_CH(1), .ACC_W(8), .LOCK_CYCLES(4)) dut8 (
        .refclk (refclk), .rst (rst8), .wr_en (wr_en8), .wr_ch (wr_ch8),
        .wr_inc (wr_inc8), .sync (sync8), .ce_en (ce_en8), .ce (ce8), .locked (locked8)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic check_near(input string nm, input int act, input int exp_v);
        n_tests++;
        if (act < exp_v - 1 || act > exp_v + 1) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +/-1", nm, act, exp_v);
        end
    endtask

    task automatic expect_at(input int unsigned c, input logic [6:0] m, input logic [6:0] v,
                             input bit cklk, input bit lk, input string nm);
        q_cyc.push_back(c);
        q_mask.push_back(m);
        q_ce.push_back(v);
        q_cklk.push_back(cklk);
        q_lk.push_back(lk);
        q_name.push_back(nm);
    endtask

    // Monitor: compares every queued expectation on the cycle it names.
    always @(negedge refclk) begin
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            if (q_cyc[0] < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: missed at cycle %0d (now %0d)", q_name[0], q_cyc[0], cyc);
            end else begin
                check_val($sformatf("%s/ce@%0d", q_name[0], cyc),
                          32'(ce & q_mask[0]), 32'(q_ce[0] & q_mask[0]));
                if (q_cklk[0])
                    check_val($sformatf("%s/locked@%0d", q_name[0], cyc),
                              32'(locked), 32'(q_lk[0]));
            end
            void'(q_cyc.pop_front());
            void'(q_mask.pop_front());
            void'(q_ce.pop_front());
            void'(q_cklk.pop_front());
            void'(q_lk.pop_front());
            void'(q_name.pop_front());
        end
    end

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge refclk);
    endtask

    task automatic do_write(input logic [3:0] ch, input logic [23:0] inc, output int unsigned w);
        wr_en  = 1'b1;
        wr_ch  = ch;
        wr_inc = inc;
        w      = cyc + 1;
        @(negedge refclk);
        wr_en  = 1'b0;
    endtask

    initial begin
        #(400000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w, x, y, z, s, r, m, w8;
        int          cnt[7];
        int          mhz[7];
        int          exp_cnt[7];
        int          lows;
        int unsigned low_at[2];

        mhz     = '{16, 24, 32, 40, 48, 96, 80};
        exp_cnt = '{1600, 2400, 3200, 4000, 4800, 9600, 8000};

        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_inc = '0; sync = 1'b0; ce_en = '1;
        rst8 = 1'b1; wr_en8 = 1'b0; wr_ch8 = '0; wr_inc8 = '0; sync8 = 1'b0; ce_en8 = 1'b1;

        // Reset state
        @(negedge refclk);
        expect_at(cyc + 1, 7'h7F, 7'h00, 1'b1, 1'b0, "reset");
        repeat (3) @(negedge refclk);
        check_val("reset8/ce", 32'(ce8), 32'd0);
        check_val("reset8/locked", 32'(locked8), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge refclk);

        // Quarter-rate channel 0, first pulse 4 edges after write, lock after 1024
        do_write(4'd0, 24'h400000, w);
        expect_at(w + 1, 7'h7F, 7'h00, 1'b1, 1'b0, "quarter");
        expect_at(w + 2, 7'h7F, 7'h00, 1'b0, 1'b0, "quarter");
        expect_at(w + 3, 7'h7F, 7'h00, 1'b0, 1'b0, "quarter");
        expect_at(w + 4, 7'h7F, 7'h01, 1'b0, 1'b0, "quarter");
        expect_at(w + 5, 7'h7F, 7'h00, 1'b0, 1'b0, "quarter");
        expect_at(w + 8, 7'h7F, 7'h01, 1'b0, 1'b0, "quarter");
        expect_at(w + 1023, 7'h00, 7'h00, 1'b1, 1'b0, "lock_pre");
        expect_at(w + 1024, 7'h7F, 7'h01, 1'b1, 1'b1, "lock_rise");
        wait_until(w + 1030);

        // Write to a nonexistent channel is ignored
        do_write(4'd9, 24'h123456, x);
        m = x + 1 + ((4 - ((x + 1 - w) % 4)) % 4);
        expect_at(x + 1, 7'h00, 7'h00, 1'b1, 1'b1, "badch_lock");
        expect_at(m, 7'h7F, 7'h01, 1'b1, 1'b1, "badch_ce");
        expect_at(m + 1, 7'h7F, 7'h00, 1'b0, 1'b0, "badch_ce");
        expect_at(m + 5, 7'h00, 7'h00, 1'b1, 1'b1, "badch_lock");
        wait_until(m + 8);

        // ce_en gating keeps the accumulator running
        do_write(4'd3, 24'h400000, y);
        expect_at(y + 1, 7'h00, 7'h00, 1'b1, 1'b0, "ceen_lockdrop");
        expect_at(y + 4, 7'h08, 7'h08, 1'b0, 1'b0, "ceen_on");
        wait_until(y + 5);
        ce_en[3] = 1'b0;
        expect_at(y + 8, 7'h08, 7'h00, 1'b0, 1'b0, "ceen_gated");
        expect_at(y + 12, 7'h08, 7'h00, 1'b0, 1'b0, "ceen_gated");
        wait_until(y + 13);
        ce_en[3] = 1'b1;
        expect_at(y + 16, 7'h08, 7'h08, 1'b0, 1'b0, "ceen_resume");
        expect_at(y + 17, 7'h08, 7'h00, 1'b0, 1'b0, "ceen_resume");
        wait_until(y + 20);

        // Half-rate channel 2, then sync on an edge where it would pulse
        do_write(4'd2, 24'h800000, z);
        expect_at(z + 2, 7'h04, 7'h04, 1'b0, 1'b0, "half");
        expect_at(z + 3, 7'h04, 7'h00, 1'b0, 1'b0, "half");
        expect_at(z + 1030, 7'h00, 7'h00, 1'b1, 1'b1, "presync_lock");
        wait_until(z + 1031);
        sync = 1'b1;
        s = cyc + 1;
        expect_at(s, 7'h7F, 7'h00, 1'b1, 1'b0, "sync_edge");
        @(negedge refclk);
        sync = 1'b0;
        expect_at(s + 1, 7'h7F, 7'h00, 1'b0, 1'b0, "postsync");
        expect_at(s + 2, 7'h7F, 7'h04, 1'b0, 1'b0, "postsync");
        expect_at(s + 3, 7'h7F, 7'h00, 1'b0, 1'b0, "postsync");
        expect_at(s + 4, 7'h7F, 7'h0D, 1'b0, 1'b0, "postsync");
        expect_at(s + 1023, 7'h00, 7'h00, 1'b1, 1'b0, "sync_lock_pre");
        expect_at(s + 1024, 7'h00, 7'h00, 1'b1, 1'b1, "sync_lock_rise");
        wait_until(s + 1030);

        // 96 MHz reference, pulse rates over 9600 cycles
        for (int i = 0; i < 7; i++) begin
            do_write(4'(i), 24'(inc_from_hz(64'(mhz[i]) * 64'd1000000, 64'd96000000, 24)), w);
        end
        sync = 1'b1;
        @(negedge refclk);
        sync = 1'b0;
        for (int i = 0; i < 7; i++) cnt[i] = 0;
        repeat (9600) begin
            @(negedge refclk);
            for (int i = 0; i < 7; i++) cnt[i] += int'(ce[i]);
        end
        for (int i = 0; i < 7; i++)
            check_near($sformatf("rate_ch%0d_%0dMHz", i, mhz[i]), cnt[i], exp_cnt[i]);

        // Reset together with write and sync
        rst = 1'b1; wr_en = 1'b1; wr_ch = 4'd1; wr_inc = 24'h800000; sync = 1'b1;
        r = cyc + 1;
        expect_at(r, 7'h7F, 7'h00, 1'b1, 1'b0, "rst_mid");
        @(negedge refclk);
        rst = 1'b0; wr_en = 1'b0; sync = 1'b0;
        expect_at(r + 1, 7'h7F, 7'h00, 1'b0, 1'b0, "rst_quiet");
        expect_at(r + 2, 7'h7F, 7'h00, 1'b0, 1'b0, "rst_quiet");
        expect_at(r + 5, 7'h7F, 7'h00, 1'b1, 1'b0, "rst_quiet");
        expect_at(r + 40, 7'h7F, 7'h00, 1'b0, 1'b0, "rst_quiet");
        expect_at(r + 300, 7'h7F, 7'h00, 1'b0, 1'b0, "rst_quiet");
        wait_until(r + 305);

        // 8-bit instance, inc = 0xFF: one low cycle per 256
        rst8 = 1'b0;
        @(negedge refclk);
        wr_en8 = 1'b1; wr_inc8 = 8'hFF;
        w8 = cyc + 1;
        @(negedge refclk);
        wr_en8 = 1'b0;
        lows = 0;
        low_at = '{0, 0};
        repeat (512) begin
            @(negedge refclk);
            if (ce8 == 1'b0) begin
                if (lows < 2) low_at[lows] = cyc;
                lows++;
            end
            if (cyc == w8 + 3) check_val("acc8/lock_pre", 32'(locked8), 32'd0);
            if (cyc == w8 + 4) check_val("acc8/lock_rise", 32'(locked8), 32'd1);
        end
        check_val("acc8/low_count", 32'(lows), 32'd2);
        check_val("acc8/first_low", low_at[0], w8 + 1);
        check_val("acc8/low_spacing", low_at[1] - low_at[0], 32'd256);

        @(negedge refclk);
        check_val("scoreboard_drained", 32'(q_cyc.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
